// File: rtl/img_pkg.sv
// -----------------------------------------------------------------------------
// img_pkg
// Shared constants and types for the mode-2 image fetch path.
//   MAX_ROW / MAX_COL : image geometry (rows, words per row)
//   ROW_W / LEN_W     : widths of the row counter and transfer length
//   FETCH_LEN         : mode-2 window length (three full rows)
//   rf_state_e        : row_fetch_sequencer FSM states
// -----------------------------------------------------------------------------
package img_pkg;

    localparam int MAX_ROW   = 360;
    localparam int MAX_COL   = 540;
    localparam int ROW_W     = 10;
    localparam int LEN_W     = 20;
    localparam int FETCH_LEN = 3 * MAX_COL;

    typedef enum logic [1:0] {
        RF_IDLE  = 2'd0,
        RF_ISSUE = 2'd1,
        RF_DRAIN = 2'd2,
        RF_DONE  = 2'd3
    } rf_state_e;

endpackage

// File: rtl/row_fetch_sequencer_bram_rd_pipe.sv
// -----------------------------------------------------------------------------
// bram_rd_pipe
// RD_LAT-deep delay line that tracks outstanding BRAM reads. Each stage holds
// a valid bit and the destination index of the word in flight, so the output
// stage lines up with the BRAM read data.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous clear of all in-flight valids
//   push_vld   : a read is being issued this cycle
//   push_idx   : index tagged onto that read
//   out_vld    : read data for out_idx is on the BRAM port this cycle
//   out_idx    : index of the word currently returning
// -----------------------------------------------------------------------------
module bram_rd_pipe #(
    parameter int RD_LAT = 2,
    parameter int IDX_W  = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push_vld,
    input  logic [IDX_W-1:0] push_idx,
    output logic             out_vld,
    output logic [IDX_W-1:0] out_idx
);

    // Stage 0 is the combinational input; stages 1..RD_LAT are registers.
    logic [RD_LAT:1]            vld_q;
    logic [RD_LAT:1][IDX_W-1:0] idx_q;
    logic [RD_LAT:0]            vld_pipe;
    logic [RD_LAT:0][IDX_W-1:0] idx_pipe;

    always_comb begin
        vld_pipe = {vld_q, push_vld};
        idx_pipe = {idx_q, push_idx};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            idx_q <= '0;
        end else begin
            // Indices need no clearing: they are only looked at with a valid.
            vld_q <= flush ? '0 : vld_pipe[RD_LAT-1:0];
            idx_q <= idx_pipe[RD_LAT-1:0];
        end
    end

    assign out_vld = vld_pipe[RD_LAT];
    assign out_idx = idx_pipe[RD_LAT];

endmodule

// File: rtl/row_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// row_fetch_sequencer
// Mode-2 fetch engine. Each controller FETCH phase streams a window of rows
// r-1, r, r+1 (clamped at the image borders) from the image BRAM into the
// core's line buffer, then pulses fetch_done_o. Also owns the image row
// counter r, advanced by core_done_i.
//   clk, rst_n     : clock, asynchronous active-low reset
//   fetch_run_i    : level, high while the controller is in FETCH
//   cnt_len_i      : words per transfer (normally 3*MAX_COL)
//   core_done_i    : pulse, advance row counter (ignored while busy)
//   row_clr_i      : pulse, clear row counter (wins over core_done_i)
//   bram_en_o / bram_addr_o / bram_rdata_i : image BRAM read port
//   buf_we_o / buf_waddr_o / buf_wdata_o   : line-buffer write port
//   fetch_done_o   : one-cycle pulse, transfer complete
//   busy_o         : transfer in progress (issuing or draining)
//   cnt_img_row_o  : current row counter
// -----------------------------------------------------------------------------
module row_fetch_sequencer #(
    parameter int MAX_ROW = img_pkg::MAX_ROW,
    parameter int MAX_COL = img_pkg::MAX_COL,
    parameter int DATA_W  = 8,
    parameter int RD_LAT  = 2,
    parameter int ADDR_W  = 18,
    parameter int BUF_AW  = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      fetch_run_i,
    input  logic [img_pkg::LEN_W-1:0] cnt_len_i,
    input  logic                      core_done_i,
    input  logic                      row_clr_i,
    output logic                      bram_en_o,
    output logic [ADDR_W-1:0]         bram_addr_o,
    input  logic [DATA_W-1:0]         bram_rdata_i,
    output logic                      buf_we_o,
    output logic [BUF_AW-1:0]         buf_waddr_o,
    output logic [DATA_W-1:0]         buf_wdata_o,
    output logic                      fetch_done_o,
    output logic                      busy_o,
    output logic [img_pkg::ROW_W-1:0] cnt_img_row_o
);

    import img_pkg::*;

    localparam int COL_W  = (MAX_COL > 1) ? $clog2(MAX_COL) : 1;
    // Unclamped source row r-1+seg; two spare bits cover the -1 start and
    // lengths far beyond three rows.
    localparam int UROW_W = LEN_W + 2;

    localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(MAX_COL - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(MAX_ROW - 1);
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(MAX_COL);
    localparam logic [UROW_W-1:0] UROW_HI    = UROW_W'(MAX_ROW - 2);

    rf_state_e state_q, state_d;

    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  word_q;
    logic [COL_W-1:0]  col_q;
    logic [UROW_W-1:0] urow_q;      // r-1+seg, two's complement
    logic [ADDR_W-1:0] src_base_q;  // clamp(urow)*MAX_COL
    logic [ROW_W-1:0]  row_q;
    logic [ADDR_W-1:0] row_base_q;  // row_q*MAX_COL, kept alongside the counter
    logic              in_done_q;

    logic              busy;
    logic              abort;
    logic              start;
    logic              issue;
    logic              last_word;
    logic              pipe_vld;
    logic [BUF_AW:0]   pipe_idx;    // {last word flag, buffer index}

    assign busy      = (state_q == RF_ISSUE) || (state_q == RF_DRAIN);
    assign abort     = busy && !fetch_run_i;
    assign start     = (state_q == RF_IDLE) && fetch_run_i;
    assign issue     = (state_q == RF_ISSUE) && fetch_run_i;
    assign last_word = (word_q == len_q - LEN_W'(1));

    // Tagging the final word lets DRAIN finish on its write-back without a
    // separate occupancy counter.
    bram_rd_pipe #(
        .RD_LAT (RD_LAT),
        .IDX_W  (BUF_AW + 1)
    ) u_rd_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (abort),
        .push_vld (issue),
        .push_idx ({last_word, word_q[BUF_AW-1:0]}),
        .out_vld  (pipe_vld),
        .out_idx  (pipe_idx)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RF_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        bram_en_o    = 1'b0;
        bram_addr_o  = '0;
        buf_we_o     = 1'b0;
        buf_waddr_o  = '0;
        buf_wdata_o  = '0;
        fetch_done_o = 1'b0;
        busy_o       = busy;

        case (state_q)
            RF_IDLE: begin
                if (fetch_run_i)
                    state_d = (cnt_len_i == '0) ? RF_DONE : RF_ISSUE;
            end
            RF_ISSUE: begin
                if (!fetch_run_i)  state_d = RF_IDLE;
                else if (last_word) state_d = RF_DRAIN;
            end
            RF_DRAIN: begin
                if (!fetch_run_i)                 state_d = RF_IDLE;
                else if (pipe_vld && pipe_idx[BUF_AW]) state_d = RF_DONE;
            end
            RF_DONE: begin
                // Holding here until the run level drops prevents a retrigger.
                if (!fetch_run_i) state_d = RF_IDLE;
                fetch_done_o = !in_done_q;
            end
            default: state_d = RF_IDLE;
        endcase

        if (issue) begin
            bram_en_o   = 1'b1;
            bram_addr_o = src_base_q + ADDR_W'(col_q);
        end

        // An abort masks the word returning in the same cycle as well.
        if (pipe_vld && !abort) begin
            buf_we_o    = 1'b1;
            buf_waddr_o = pipe_idx[BUF_AW-1:0];
            buf_wdata_o = bram_rdata_i;
        end
    end

    // ---------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q      <= '0;
            word_q     <= '0;
            col_q      <= '0;
            urow_q     <= '0;
            src_base_q <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            in_done_q  <= 1'b0;
        end else begin
            in_done_q <= (state_q == RF_DONE);

            if (start) begin
                len_q      <= cnt_len_i;
                word_q     <= '0;
                col_q      <= '0;
                urow_q     <= UROW_W'(row_q) - UROW_W'(1);
                src_base_q <= (row_q == '0) ? '0 : row_base_q - ROW_STRIDE;
            end else if (issue) begin
                word_q <= word_q + LEN_W'(1);
                if (col_q == COL_LAST) begin
                    col_q  <= '0;
                    urow_q <= urow_q + UROW_W'(1);
                    // The clamped row only moves when the next segment's
                    // unclamped row (urow+1) lies inside 1..MAX_ROW-1.
                    if (!urow_q[UROW_W-1] && (urow_q <= UROW_HI))
                        src_base_q <= src_base_q + ROW_STRIDE;
                end else begin
                    col_q <= col_q + COL_W'(1);
                end
            end

            if (row_clr_i) begin
                row_q      <= '0;
                row_base_q <= '0;
            end else if (core_done_i && !busy) begin
                if (row_q == ROW_LAST) begin
                    row_q      <= '0;
                    row_base_q <= '0;
                end else begin
                    row_q      <= row_q + ROW_W'(1);
                    row_base_q <= row_base_q + ROW_STRIDE;
                end
            end
        end
    end

    assign cnt_img_row_o = row_q;

endmodule

// File: doc/row_fetch_sequencer.md
Name: row_fetch_sequencer

Overview:
- Mode-2 fetch engine. On each controller FETCH phase, streams one 3-row window (rows r-1, r, r+1, clamped at the image borders) from the image BRAM into the core's line buffer.
- Owns the current image row counter `cnt_img_row`, advances it on `core_done`, and raises `fetch_done` when the buffer is full.
- Sits between the top controller, the image BRAM read port and the preprocessor line buffer.

Parameters:
- MAX_ROW, 360, image rows
- MAX_COL, 540, image columns (words per row)
- DATA_W, 8, BRAM word width
- RD_LAT, 2, BRAM read latency in cycles (1..4)
- ADDR_W, 18, BRAM address width
- BUF_AW, 12, line-buffer address width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- fetch_run_i  in  1  level; high while controller is in FETCH
- cnt_len_i  in  20  words per transfer, normally 3*MAX_COL = 1620
- core_done_i  in  1  one-cycle pulse, core finished current row
- row_clr_i  in  1  synchronous clear of row counter (pulse at mode-2 entry)
- bram_en_o  out  1  BRAM read enable
- bram_addr_o  out  ADDR_W  BRAM read address
- bram_rdata_i  in  DATA_W  BRAM read data, valid RD_LAT cycles after en
- buf_we_o  out  1  line-buffer write strobe
- buf_waddr_o  out  BUF_AW  line-buffer word index, 0..len-1
- buf_wdata_o  out  DATA_W  line-buffer write data (= bram_rdata_i)
- fetch_done_o  out  1  one-cycle pulse, transfer complete
- busy_o  out  1  transfer in progress (ISSUE or DRAIN)
- cnt_img_row_o  out  10  current row, 0..MAX_ROW-1

Behaviour:
- Reset (async): state IDLE. All outputs 0; row counter 0; read pipeline invalid.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE → ISSUE when fetch_run_i=1.
  - Latch cnt_len_i; clear word count, column count and segment count.
  - If latched len = 0, go directly to DONE instead.
- ISSUE:
  - Each cycle: bram_en_o=1; bram_addr_o = src_row*MAX_COL + col.
  - Push index `word` into the read pipeline.
  - col increments; on col = MAX_COL-1, col→0 and seg++.
  - src_row = clamp(r + seg - 1, 0, MAX_ROW-1). Row 0: seg0 reads row 0. Row MAX_ROW-1: seg2 reads row MAX_ROW-1.
  - Addresses are generated incrementally with adders only; no multiplier.
  - Go to DRAIN after issuing word len-1.
- Read pipeline (RD_LAT-deep shift of valid + index):
  - Output stage drives buf_we_o, buf_waddr_o and buf_wdata_o = bram_rdata_i.
  - First buf_we_o occurs exactly RD_LAT cycles after the first bram_en_o.
- DRAIN: bram_en_o=0; → DONE once the pipeline is empty (the cycle after the last buf_we_o).
- DONE:
  - fetch_done_o=1 for exactly one cycle (the state's first cycle).
  - Stay in DONE until fetch_run_i=0, then → IDLE. This prevents retrigger.
  - Transfer of 1620 words: fetch_done_o occurs 1620+RD_LAT+1 cycles after the cycle IDLE→ISSUE is taken.
- Abort: fetch_run_i=0 in ISSUE or DRAIN →
  - Immediate → IDLE.
  - Flush the pipeline: no further buf_we_o.
  - No fetch_done_o.
- busy_o = (state==ISSUE || state==DRAIN).
- Row counter:
  - core_done_i: r→r+1, wrapping MAX_ROW-1→0.
  - row_clr_i: r→0; wins over a simultaneous core_done_i.
  - core_done_i while busy_o=1 is ignored.
  - The counter is used for address generation only at the IDLE→ISSUE transition (latched base); it is stable during a transfer.
- cnt_img_row_o is registered and reflects r; the controller compares it on core_done, before the increment takes effect.
- Length > 3*MAX_COL: segments continue with row clamping. Length is not a multiple of MAX_COL: the last segment is partial. Both are legal.

Decomposition:
- Shared package img_pkg:
  - Constants MAX_ROW, MAX_COL, ROW_W=10, LEN_W=20.
  - FSM state enum for this block.
  - Mode-2 transfer length constant FETCH_LEN = 3*MAX_COL.
- One sub-module: bram_rd_pipe (parameter RD_LAT; valid/index delay line with synchronous flush).

Test Plan:
- Reset mid-ISSUE (rst_n low for 1 cycle) → all outputs 0 asynchronously, cnt_img_row_o=0; next fetch_run_i starts cleanly from word 0.
- Row 0, len 1620, RD_LAT=2 → bram_addr_o 0..539, 0..539, 540..1079; buf_waddr_o 0..1619 contiguous; first buf_we_o 2 cycles after first bram_en_o; fetch_done_o 1623 cycles after start, 1 cycle wide.
- 359 core_done_i pulses then fetch → cnt_img_row_o=359; addresses 193320..193859 for seg0, 193860..194399 for seg1 and seg2. One more core_done_i → cnt_img_row_o=0.
- Row 100 fetch, fetch_run_i dropped at word 700 → no buf_we_o after the flush, no fetch_done_o, busy_o=0 next cycle; a re-run restarts at address 53460.
- cnt_len_i=0 → no bram_en_o; fetch_done_o on the cycle after start; holds DONE until fetch_run_i=0.
- core_done_i and row_clr_i in the same cycle at r=5 → r=0. core_done_i during busy_o → r unchanged.
